// File: rtl/accum_status_monitor_if.sv
// Bundle between the add/sub accumulator and its status monitor: the sampled
// sum/flags with control strobes going in, saturated result and statistics coming out.
interface accum_status_monitor_if #(
  parameter int N  = 8,
  parameter int CW = 4
);
  logic          en;
  logic [N-1:0]  S;
  logic          carry;
  logic          overflow;
  logic          clr;
  logic          ack;
  logic [N-1:0]  S_sat;
  logic          ov_sticky;
  logic          carry_sticky;
  logic [CW-1:0] ov_count;
  logic [CW-1:0] carry_count;
  logic [N-1:0]  max_s;
  logic [N-1:0]  min_s;
  logic          alarm;

  modport master (
    output en, S, carry, overflow, clr, ack,
    input  S_sat, ov_sticky, carry_sticky, ov_count, carry_count, max_s, min_s, alarm
  );

  modport slave (
    input  en, S, carry, overflow, clr, ack,
    output S_sat, ov_sticky, carry_sticky, ov_count, carry_count, max_s, min_s, alarm
  );
endinterface

// File: rtl/accum_status_monitor.sv
// Status monitor behind the add/sub accumulator: saturated result, sticky flags,
// saturating event counters, signed peaks and an overflow alarm that freezes sampling.
module accum_status_monitor #(
  parameter int N        = 8,
  parameter int CW       = 4,
  parameter int OV_LIMIT = 3
) (
  input  logic                   clk,
  input  logic                   aclr,
  accum_status_monitor_if.slave  mon
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_ALARM = 1'b1} state_t;

  localparam logic [N-1:0]  POS_MAX_C = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  NEG_MAX_C = {1'b1, {(N-1){1'b0}}};
  localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]   OV_LIM_C  = (CW+1)'(OV_LIMIT);

  // A wrapped overflow carries the opposite sign of the true result, so clamp the other way.
  function automatic logic [N-1:0] sat_fn(input logic [N-1:0] s, input logic ov);
    logic [N-1:0] r;
    if (!ov)
      r = s;
    else if (s[N-1])
      r = POS_MAX_C;
    else
      r = NEG_MAX_C;
    return r;
  endfunction

  function automatic logic [CW-1:0] cnt_inc_fn(input logic [CW-1:0] c, input logic hit);
    logic [CW-1:0] r;
    if (hit && (c != CNT_MAX_C))
      r = c + CNT_ONE_C;
    else
      r = c;
    return r;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [N-1:0]  s_sat_r, s_sat_nxt_s;
  logic          ov_sticky_r, ov_sticky_nxt_s;
  logic          carry_sticky_r, carry_sticky_nxt_s;
  logic [CW-1:0] ov_count_r, ov_count_nxt_s;
  logic [CW-1:0] carry_count_r, carry_count_nxt_s;
  logic [N-1:0]  max_s_r, max_s_nxt_s;
  logic [N-1:0]  min_s_r, min_s_nxt_s;
  logic          alarm_r, alarm_nxt_s;

  logic          sample_s;
  logic [N-1:0]  sat_val_s;
  logic          ov_hit_s;

  assign sample_s  = mon.en && (state_r == ST_RUN) && !mon.clr;
  assign sat_val_s = sat_fn(mon.S, mon.overflow);
  assign ov_hit_s  = sample_s && mon.overflow &&
                     (({1'b0, ov_count_r} + {1'b0, CNT_ONE_C}) >= OV_LIM_C);

  // FSM state register
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr)
      state_r <= ST_RUN;
    else
      state_r <= state_nxt_s;
  end

  // FSM next-state logic; clear outranks acknowledge
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mon.clr)
          state_nxt_s = ST_RUN;
        else if (ov_hit_s)
          state_nxt_s = ST_ALARM;
        else
          state_nxt_s = ST_RUN;
      end
      ST_ALARM: begin
        if (mon.clr || mon.ack)
          state_nxt_s = ST_RUN;
        else
          state_nxt_s = ST_ALARM;
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    s_sat_nxt_s        = s_sat_r;
    ov_sticky_nxt_s    = ov_sticky_r;
    carry_sticky_nxt_s = carry_sticky_r;
    ov_count_nxt_s     = ov_count_r;
    carry_count_nxt_s  = carry_count_r;
    max_s_nxt_s        = max_s_r;
    min_s_nxt_s        = min_s_r;
    if (mon.clr) begin
      s_sat_nxt_s        = {N{1'b0}};
      ov_sticky_nxt_s    = 1'b0;
      carry_sticky_nxt_s = 1'b0;
      ov_count_nxt_s     = {CW{1'b0}};
      carry_count_nxt_s  = {CW{1'b0}};
      max_s_nxt_s        = NEG_MAX_C;
      min_s_nxt_s        = POS_MAX_C;
    end else if (sample_s) begin
      s_sat_nxt_s        = sat_val_s;
      ov_sticky_nxt_s    = ov_sticky_r | mon.overflow;
      carry_sticky_nxt_s = carry_sticky_r | mon.carry;
      ov_count_nxt_s     = cnt_inc_fn(ov_count_r, mon.overflow);
      carry_count_nxt_s  = cnt_inc_fn(carry_count_r, mon.carry);
      if ($signed(sat_val_s) > $signed(max_s_r))
        max_s_nxt_s = sat_val_s;
      else
        max_s_nxt_s = max_s_r;
      if ($signed(sat_val_s) < $signed(min_s_r))
        min_s_nxt_s = sat_val_s;
      else
        min_s_nxt_s = min_s_r;
    end else if ((state_r == ST_ALARM) && mon.ack) begin
      ov_sticky_nxt_s = 1'b0;
      ov_count_nxt_s  = {CW{1'b0}};
    end else begin
      s_sat_nxt_s = s_sat_r;
    end
    alarm_nxt_s = (state_nxt_s == ST_ALARM);
  end

  // Monitor data registers
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      s_sat_r        <= {N{1'b0}};
      ov_sticky_r    <= 1'b0;
      carry_sticky_r <= 1'b0;
      ov_count_r     <= {CW{1'b0}};
      carry_count_r  <= {CW{1'b0}};
      max_s_r        <= NEG_MAX_C;
      min_s_r        <= POS_MAX_C;
      alarm_r        <= 1'b0;
    end else begin
      s_sat_r        <= s_sat_nxt_s;
      ov_sticky_r    <= ov_sticky_nxt_s;
      carry_sticky_r <= carry_sticky_nxt_s;
      ov_count_r     <= ov_count_nxt_s;
      carry_count_r  <= carry_count_nxt_s;
      max_s_r        <= max_s_nxt_s;
      min_s_r        <= min_s_nxt_s;
      alarm_r        <= alarm_nxt_s;
    end
  end

  assign mon.S_sat        = s_sat_r;
  assign mon.ov_sticky    = ov_sticky_r;
  assign mon.carry_sticky = carry_sticky_r;
  assign mon.ov_count     = ov_count_r;
  assign mon.carry_count  = carry_count_r;
  assign mon.max_s        = max_s_r;
  assign mon.min_s        = min_s_r;
  assign mon.alarm        = alarm_r;

endmodule

// File: tb/tb_accum_status_monitor.sv
// Self-checking bench for accum_status_monitor: stimulus table plus hand sequences,
// expected outputs queued when driven and compared one edge later.
module tb_accum_status_monitor;

  typedef struct packed {
    logic [7:0] sat;
    logic       ovs;
    logic       cs;
    logic [3:0] ovc;
    logic [3:0] cc;
    logic [7:0] mx;
    logic [7:0] mn;
    logic       al;
  } out_t;

  typedef struct packed {
    logic       en;
    logic [7:0] s;
    logic       c;
    logic       ov;
    logic       clr;
    logic       ack;
    out_t       exp;
  } vec_t;

  logic clk;
  logic aclr;
  int   n_vec;
  int   n_bad;
  out_t sb_q[$];
  vec_t vt[22];

  accum_status_monitor_if #(.N(8), .CW(4)) bus();

  accum_status_monitor #(.N(8), .CW(4), .OV_LIMIT(3)) dut (
    .clk  (clk),
    .aclr (aclr),
    .mon  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, input logic [7:0] s, input logic c,
                              input logic ov, input logic clr, input logic ack,
                              input logic [7:0] sat, input logic ovs, input logic cs,
                              input logic [3:0] ovc, input logic [3:0] cc,
                              input logic [7:0] mx, input logic [7:0] mn, input logic al);
    vec_t v;
    v.en = en; v.s = s; v.c = c; v.ov = ov; v.clr = clr; v.ack = ack;
    v.exp = '{sat, ovs, cs, ovc, cc, mx, mn, al};
    return v;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o = '{bus.S_sat, bus.ov_sticky, bus.carry_sticky, bus.ov_count, bus.carry_count,
          bus.max_s, bus.min_s, bus.alarm};
    return o;
  endfunction

  task automatic check_now(input string name, input out_t e);
    out_t a;
    a = cur_out();
    n_vec++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got sat=%h ovs=%b cs=%b ovc=%0d cc=%0d max=%h min=%h alarm=%b, want sat=%h ovs=%b cs=%b ovc=%0d cc=%0d max=%h min=%h alarm=%b",
               name, a.sat, a.ovs, a.cs, a.ovc, a.cc, a.mx, a.mn, a.al,
               e.sat, e.ovs, e.cs, e.ovc, e.cc, e.mx, e.mn, e.al);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v, input string name);
    out_t e;
    bus.en = v.en; bus.S = v.s; bus.carry = v.c; bus.overflow = v.ov;
    bus.clr = v.clr; bus.ack = v.ack;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_now(name, e);
  endtask

  initial begin
    out_t rst_o;
    vec_t v;
    int   cc_m;
    n_vec = 0;
    n_bad = 0;
    rst_o = '{8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h80, 8'h7F, 1'b0};

    //        en   S      c     ov    clr   ack   sat    ovs   cs    ovc   cc    max    min    alarm
    vt[0]  = mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 4'd1, 4'd0, 8'h7F, 8'h7F, 1'b0);
    vt[1]  = mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd2, 4'd0, 8'h7F, 8'h80, 1'b0);
    vt[2]  = mk(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 4'd2, 4'd0, 8'h7F, 8'h80, 1'b0);
    vt[3]  = mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h80, 8'h7F, 1'b0);
    vt[4]  = mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0, 4'd0, 4'd0, 8'h05, 8'h05, 1'b0);
    vt[5]  = mk(1'b1, 8'hFB, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFB, 1'b0, 1'b0, 4'd0, 4'd0, 8'h05, 8'hFB, 1'b0);
    vt[6]  = mk(1'b1, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 8'h40, 1'b0, 1'b0, 4'd0, 4'd0, 8'h40, 8'hFB, 1'b0);
    vt[7]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h40, 8'hFB, 1'b0);
    vt[8]  = mk(1'b0, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h40, 8'hFB, 1'b0);
    vt[9]  = mk(1'b1, 8'h90, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd1, 4'd1, 8'h7F, 8'hFB, 1'b0);
    vt[10] = mk(1'b1, 8'h70, 1'b0, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 4'd2, 4'd1, 8'h7F, 8'h80, 1'b0);
    vt[11] = mk(1'b1, 8'h85, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd3, 4'd2, 8'h7F, 8'h80, 1'b1);
    vt[12] = mk(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd3, 4'd2, 8'h7F, 8'h80, 1'b1);
    vt[13] = mk(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 4'd0, 4'd2, 8'h7F, 8'h80, 1'b0);
    vt[14] = mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b1, 4'd0, 4'd2, 8'h7F, 8'h80, 1'b0);
    vt[15] = mk(1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 4'd0, 4'd2, 8'h7F, 8'h80, 1'b0);
    vt[16] = mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd1, 4'd2, 8'h7F, 8'h80, 1'b0);
    vt[17] = mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd2, 4'd2, 8'h7F, 8'h80, 1'b0);
    vt[18] = mk(1'b1, 8'h90, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1, 4'd3, 4'd2, 8'h7F, 8'h80, 1'b1);
    vt[19] = mk(1'b1, 8'h44, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h80, 8'h7F, 1'b0);
    vt[20] = mk(1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd0, 8'h80, 8'h7F, 1'b0);
    vt[21] = mk(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 4'd0, 4'd0, 8'h22, 8'h22, 1'b0);

    bus.en = 1'b0; bus.S = 8'h00; bus.carry = 1'b0; bus.overflow = 1'b0;
    bus.clr = 1'b0; bus.ack = 1'b0;
    aclr = 1'b0;
    #13;
    aclr = 1'b1;
    #2;
    check_now("reset_async", rst_o);
    @(posedge clk);
    #3;
    aclr = 1'b0;
    #1;
    check_now("reset_release", rst_o);

    for (int i = 0; i < 22; i++)
      apply(vt[i], $sformatf("table[%0d]", i));

    // Carry counter saturates at 15 and holds.
    for (int i = 0; i < 20; i++) begin
      cc_m = (i + 1 > 15) ? 15 : i + 1;
      v = mk(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 4'd0, 4'(cc_m),
             8'h22, 8'h01, 1'b0);
      apply(v, $sformatf("carry_sat[%0d]", i));
    end
    for (int i = 0; i < 4; i++) begin
      v = mk(1'b0, 8'h7E, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 4'd0, 4'd15,
             8'h22, 8'h01, 1'b0);
      apply(v, $sformatf("en_low[%0d]", i));
    end

    // Mid-cycle asynchronous reset, then a sample on the very next edge.
    #3;
    aclr = 1'b1;
    #1;
    check_now("aclr_midcycle", rst_o);
    #1;
    aclr = 1'b0;
    v = mk(1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 4'd0, 4'd0,
           8'h11, 8'h11, 1'b0);
    apply(v, "first_after_aclr");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
